// File: rtl/alu_uop_decoder_pkg.sv
// Shared encodings for the ALU micro-op decoder: opcodes, funct7 groups,
// uop class/op enums and the combinational decode function.
package alu_uop_decoder_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   typedef enum logic [2:0] {
      CLS_NONE  = 3'd0,
      CLS_ADD   = 3'd1,
      CLS_LOGIC = 3'd2,
      CLS_SHIFT = 3'd3,
      CLS_CMP   = 3'd4,
      CLS_MUL   = 3'd5,
      CLS_DIV   = 3'd6
   } uop_class_e;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_SLL    = 5'd2,
      OP_SLT    = 5'd3,
      OP_SLTU   = 5'd4,
      OP_XOR    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_OR     = 5'd8,
      OP_AND    = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17
   } uop_op_e;

   typedef struct packed {
      uop_class_e uop_class;
      uop_op_e    uop_op;
      logic       use_imm;
      logic       illegal;
   } uop_t;

   localparam int UOP_W = $bits(uop_t);

   function automatic uop_class_e op_class(input uop_op_e op);
      case (op)
         OP_ADD, OP_SUB:                         op_class = CLS_ADD;
         OP_XOR, OP_OR, OP_AND:                  op_class = CLS_LOGIC;
         OP_SLL, OP_SRL, OP_SRA:                 op_class = CLS_SHIFT;
         OP_SLT, OP_SLTU:                        op_class = CLS_CMP;
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU:   op_class = CLS_MUL;
         OP_DIV, OP_DIVU, OP_REM, OP_REMU:       op_class = CLS_DIV;
         default:                                op_class = CLS_NONE;
      endcase
   endfunction

   // funct3 ordering shared by OP/funct7=0 and the unambiguous OP-IMM rows
   function automatic uop_op_e base_op(input logic [2:0] funct3);
      case (funct3)
         3'd0:    base_op = OP_ADD;
         3'd1:    base_op = OP_SLL;
         3'd2:    base_op = OP_SLT;
         3'd3:    base_op = OP_SLTU;
         3'd4:    base_op = OP_XOR;
         3'd5:    base_op = OP_SRL;
         3'd6:    base_op = OP_OR;
         default: base_op = OP_AND;
      endcase
   endfunction

   function automatic uop_t decode_uop(input logic [6:0] opcode,
                                       input logic [2:0] funct3,
                                       input logic [6:0] funct7,
                                       input logic       en_m);
      uop_t    u;
      uop_op_e op;
      logic    ok;
      op = OP_ADD;
      ok = 1'b0;
      if (opcode == OPC_OP) begin
         if (funct7 == F7_BASE) begin
            op = base_op(funct3);
            ok = 1'b1;
         end else if (funct7 == F7_ALT) begin
            if (funct3 == 3'b000) begin
               op = OP_SUB;
               ok = 1'b1;
            end else if (funct3 == 3'b101) begin
               op = OP_SRA;
               ok = 1'b1;
            end
         end else if (funct7 == F7_MULDIV && en_m) begin
            op = uop_op_e'(5'(OP_MUL) + {2'b00, funct3});
            ok = 1'b1;
         end
      end else if (opcode == OPC_OP_IMM) begin
         // Shift-immediates reuse funct7 as the shift-type selector
         case (funct3)
            3'b001: begin
               if (funct7 == F7_BASE) begin
                  op = OP_SLL;
                  ok = 1'b1;
               end
            end
            3'b101: begin
               if (funct7 == F7_BASE) begin
                  op = OP_SRL;
                  ok = 1'b1;
               end else if (funct7 == F7_ALT) begin
                  op = OP_SRA;
                  ok = 1'b1;
               end
            end
            default: begin
               op = base_op(funct3);
               ok = 1'b1;
            end
         endcase
      end
      u.use_imm   = (opcode == OPC_OP_IMM);
      u.illegal   = ~ok;
      u.uop_op    = ok ? op : OP_ADD;
      u.uop_class = ok ? op_class(op) : CLS_NONE;
      return u;
   endfunction

endpackage

// File: rtl/alu_uop_decoder_if.sv
// Instruction-in / uop-out bus of the ALU micro-op decoder.
interface alu_uop_decoder_if #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       uop_class;
   logic [4:0]       uop_op;
   logic             use_imm;
   logic             illegal;
   logic [TAG_W-1:0] out_tag;
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output in_valid, opcode, funct3, funct7, in_tag, flush, out_ready,
      input  in_ready, out_valid, uop_class, uop_op, use_imm, illegal, out_tag, illegal_cnt
   );

   modport slave (
      input  in_valid, opcode, funct3, funct7, in_tag, flush, out_ready,
      output in_ready, out_valid, uop_class, uop_op, use_imm, illegal, out_tag, illegal_cnt
   );
endinterface

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer: output register plus one skid register, so in_ready
// depends only on local state and full throughput holds with out_ready high.
module alu_skid_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);
   logic              vld_p0;
   logic [DATA_W-1:0] data_p0;
   logic              skid_vld_p0;
   logic [DATA_W-1:0] skid_data_p0;
   logic              accept;
   logic              out_free;

   assign in_ready  = ~skid_vld_p0 & ~reset;
   assign accept    = in_valid & in_ready;
   assign out_free  = ~vld_p0 | out_ready;
   assign out_valid = vld_p0;
   assign out_data  = data_p0;

   // Stage p0: output register / skid register control
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         vld_p0      <= 1'b0;
         skid_vld_p0 <= 1'b0;
      end else begin
         if (out_free) vld_p0 <= skid_vld_p0 | accept;
         skid_vld_p0 <= ~out_free & (skid_vld_p0 | accept);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_p0 <= '0;
      end else if (out_free) begin
         if (skid_vld_p0)  data_p0 <= skid_data_p0;
         else if (accept)  data_p0 <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!out_free && accept) skid_data_p0 <= in_data;
   end

endmodule

// File: rtl/alu_uop_decoder.sv
// ALU micro-op decoder: combinational RV32I/M OP/OP-IMM decode into a
// one-cycle skid-buffered uop stream, with a saturating illegal counter.
module alu_uop_decoder
   import alu_uop_decoder_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int EN_M  = 0,
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               reset,
   alu_uop_decoder_if.slave  bus
);
   localparam int PAY_W = UOP_W + TAG_W;

   uop_t             dec_uop;
   uop_t             out_uop;
   logic [PAY_W-1:0] out_data;
   logic             accept;
   logic [CNT_W-1:0] cnt_p0;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign dec_uop = decode_uop(bus.opcode, bus.funct3, bus.funct7, EN_M != 0);
   assign accept  = bus.in_valid & bus.in_ready;

   alu_skid_buf #(.DATA_W(PAY_W)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   ({dec_uop, bus.in_tag}),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (out_data)
   );

   assign out_uop       = out_data[PAY_W-1:TAG_W];
   assign bus.out_tag   = out_data[TAG_W-1:0];
   assign bus.uop_class = out_uop.uop_class;
   assign bus.uop_op    = out_uop.uop_op;
   assign bus.use_imm   = out_uop.use_imm;
   assign bus.illegal   = out_uop.illegal;

   // Stage p0: illegal counter, updated alongside the uop it counts
   always_ff @(posedge clk) begin
      if (reset)                                      cnt_p0 <= '0;
      else if (accept && dec_uop.illegal && !bus.flush) cnt_p0 <= sat_inc(cnt_p0);
   end

   assign bus.illegal_cnt = cnt_p0;

endmodule
